// File: rtl/can_frame_tx_if.sv
// Host-side request/status bundle for can_frame_tx.
// master = host driving frame requests; slave = the transmitter.
interface can_frame_tx_if;
  logic        start;
  logic [28:0] id_in;
  logic        ide_in;
  logic        rtr_in;
  logic [3:0]  dlc_in;
  logic [63:0] data_in;
  logic        error_in;
  logic        busy;
  logic        done;
  logic        arb_lost;
  logic        error_out;

  modport master (
    output start, id_in, ide_in, rtr_in, dlc_in, data_in, error_in,
    input  busy, done, arb_lost, error_out
  );

  modport slave (
    input  start, id_in, ide_in, rtr_in, dlc_in, data_in, error_in,
    output busy, done, arb_lost, error_out
  );
endinterface

// File: rtl/can_frame_tx.sv
// CAN 2.0A/B frame transmitter: serialises a latched frame onto tx_bit one bit per
// bit_tick, with CRC-15 and bit stuffing, and checks the ACK slot via rx_bit.
// Optional arbitration-loss detection is built when CAN_TX_ARB_EN is defined.
// state_q/cnt_q name the field and index of the last non-stuff bit on the wire;
// stuff_q marks that the wire currently carries a stuff bit following it.
module can_frame_tx #(
  parameter logic [14:0] CRC_POLY  = 15'h4599,
  parameter int unsigned MAX_BYTES = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           bit_tick,
  input  logic           rx_bit,
  output logic           tx_bit,
  can_frame_tx_if.slave  host
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned RUN_W = 3;
  localparam int unsigned CRC_W = 15;

  typedef enum logic [4:0] {
    IDLE, START_FRAME, IDENTIFIER_A, RTR_SRR, IDE, IDENTIFIER_B, RTR,
    RESERVED_1, RESERVED_0, DLC, DATA, CRC, CRC_DELIMITER, ACK_SLOT,
    ACK_DELIMITER, END_OF_FRAME, INTERFRAME
  } state_e;

  state_e             state_q, state_d, nxt_state;
  logic [CNT_W-1:0]   cnt_q, cnt_d, nxt_cnt, data_last;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic               stuff_q, stuff_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [28:0]        id_q, id_d;
  logic               ide_q, ide_d, rtr_q, rtr_d;
  logic [3:0]         dlc_q, dlc_d, nbytes;
  logic [63:0]        data_q, data_d;
  logic [10:0]        id_a;
  logic [17:0]        id_b;
  logic [6:0]         data_bits;
  logic               nxt_bit, frame_end, stuff_zone, crc_zone, crc_fb;
  logic               arb_hit;
`ifdef CAN_TX_ARB_EN
  logic               arb_q, arb_d;
`endif

  assign id_a      = ide_q ? id_q[28:18] : id_q[10:0];
  assign id_b      = id_q[17:0];
  assign nbytes    = (dlc_q > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : dlc_q;
  assign data_bits = {nbytes, 3'b000};
  assign data_last = CNT_W'(data_bits - 7'd1);

  // Field position that follows the current non-stuff bit
  always_comb begin
    nxt_state = state_q;
    nxt_cnt   = cnt_q + 6'd1;
    frame_end = 1'b0;
    case (state_q)
      IDLE:         begin nxt_state = START_FRAME;  nxt_cnt = '0; end
      START_FRAME:  begin nxt_state = IDENTIFIER_A; nxt_cnt = '0; end
      IDENTIFIER_A: if (cnt_q == 6'd10) begin nxt_state = RTR_SRR; nxt_cnt = '0; end
      RTR_SRR:      begin nxt_state = IDE; nxt_cnt = '0; end
      IDE:          begin nxt_state = ide_q ? IDENTIFIER_B : RESERVED_0; nxt_cnt = '0; end
      IDENTIFIER_B: if (cnt_q == 6'd17) begin nxt_state = RTR; nxt_cnt = '0; end
      RTR:          begin nxt_state = RESERVED_1; nxt_cnt = '0; end
      RESERVED_1:   begin nxt_state = RESERVED_0; nxt_cnt = '0; end
      RESERVED_0:   begin nxt_state = DLC; nxt_cnt = '0; end
      DLC: if (cnt_q == 6'd3) begin
        nxt_state = (!rtr_q && dlc_q != 4'd0) ? DATA : CRC;
        nxt_cnt   = '0;
      end
      DATA:          if (cnt_q == data_last) begin nxt_state = CRC; nxt_cnt = '0; end
      CRC:           if (cnt_q == 6'd14) begin nxt_state = CRC_DELIMITER; nxt_cnt = '0; end
      CRC_DELIMITER: begin nxt_state = ACK_SLOT; nxt_cnt = '0; end
      ACK_SLOT:      begin nxt_state = ACK_DELIMITER; nxt_cnt = '0; end
      ACK_DELIMITER: begin nxt_state = END_OF_FRAME; nxt_cnt = '0; end
      END_OF_FRAME:  if (cnt_q == 6'd6) begin nxt_state = INTERFRAME; nxt_cnt = '0; end
      INTERFRAME:    if (cnt_q == 6'd2) frame_end = 1'b1;
      default:       begin nxt_state = IDLE; nxt_cnt = '0; end
    endcase
  end

  // Bus level of the next field bit
  always_comb begin
    nxt_bit = 1'b1;
    case (nxt_state)
      START_FRAME:  nxt_bit = 1'b0;
      IDENTIFIER_A: nxt_bit = id_a[4'(4'd10 - 4'(nxt_cnt))];
      RTR_SRR:      nxt_bit = ide_q ? 1'b1 : rtr_q;
      IDE:          nxt_bit = ide_q;
      IDENTIFIER_B: nxt_bit = id_b[5'(5'd17 - 5'(nxt_cnt))];
      RTR:          nxt_bit = rtr_q;
      RESERVED_1:   nxt_bit = 1'b0;
      RESERVED_0:   nxt_bit = 1'b0;
      DLC:          nxt_bit = dlc_q[2'(2'd3 - 2'(nxt_cnt))];
      DATA:         nxt_bit = data_q[6'd63 - nxt_cnt];
      CRC:          nxt_bit = crc_q[4'(4'd14 - 4'(nxt_cnt))];
      default:      nxt_bit = 1'b1;
    endcase
  end

  assign stuff_zone = state_q inside {START_FRAME, IDENTIFIER_A, RTR_SRR, IDE, IDENTIFIER_B,
                                      RTR, RESERVED_1, RESERVED_0, DLC, DATA, CRC};
  assign crc_zone   = nxt_state inside {START_FRAME, IDENTIFIER_A, RTR_SRR, IDE, IDENTIFIER_B,
                                        RTR, RESERVED_1, RESERVED_0, DLC, DATA};
  assign crc_fb     = nxt_bit ^ crc_q[14];

  // Arbitration loss: recessive driven in an arbitration field but dominant seen
`ifdef CAN_TX_ARB_EN
  assign arb_hit = busy_q && bit_tick && tx_q && !rx_bit &&
                   (state_q inside {IDENTIFIER_A, RTR_SRR, IDE, IDENTIFIER_B, RTR});
`else
  assign arb_hit = 1'b0;
`endif

  // Frame sequencing: accept, abort, stuff/advance per tick, ACK check
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    crc_d   = crc_q;
    stuff_d = stuff_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    id_d    = id_q;
    ide_d   = ide_q;
    rtr_d   = rtr_q;
    dlc_d   = dlc_q;
    data_d  = data_q;
`ifdef CAN_TX_ARB_EN
    arb_d   = 1'b0;
`endif
    if (host.error_in) begin
      state_d = IDLE; cnt_d = '0; run_d = '0; stuff_d = 1'b0; tx_d = 1'b1; busy_d = 1'b0;
    end else if (!busy_q) begin
      if (host.start) begin
        busy_d  = 1'b1;
        state_d = IDLE; cnt_d = '0; run_d = '0; stuff_d = 1'b0; crc_d = '0;
        id_d    = host.id_in;
        ide_d   = host.ide_in;
        rtr_d   = host.rtr_in;
        dlc_d   = host.dlc_in;
        data_d  = host.data_in;
      end
    end else if (bit_tick) begin
      if (arb_hit) begin
`ifdef CAN_TX_ARB_EN
        arb_d = 1'b1;
`endif
        state_d = IDLE; cnt_d = '0; run_d = '0; stuff_d = 1'b0; tx_d = 1'b1; busy_d = 1'b0;
      end else begin
        if (state_q == ACK_SLOT && rx_bit) err_d = 1'b1;
        if (stuff_zone && run_q == 3'd5) begin
          tx_d = ~tx_q; stuff_d = 1'b1; run_d = 3'd1;
        end else if (frame_end) begin
          state_d = IDLE; cnt_d = '0; run_d = '0; stuff_d = 1'b0; tx_d = 1'b1;
          busy_d = 1'b0; done_d = 1'b1;
        end else begin
          state_d = nxt_state;
          cnt_d   = nxt_cnt;
          stuff_d = 1'b0;
          tx_d    = nxt_bit;
          run_d   = (nxt_bit == tx_q) ? RUN_W'(run_q + 3'd1) : 3'd1;
          if (crc_zone) crc_d = {crc_q[13:0], 1'b0} ^ (crc_fb ? CRC_POLY : 15'd0);
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      run_q   <= '0;
      crc_q   <= '0;
      stuff_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= '0;
      ide_q   <= 1'b0;
      rtr_q   <= 1'b0;
      dlc_q   <= '0;
      data_q  <= '0;
`ifdef CAN_TX_ARB_EN
      arb_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      crc_q   <= crc_d;
      stuff_q <= stuff_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      id_q    <= id_d;
      ide_q   <= ide_d;
      rtr_q   <= rtr_d;
      dlc_q   <= dlc_d;
      data_q  <= data_d;
`ifdef CAN_TX_ARB_EN
      arb_q   <= arb_d;
`endif
    end
  end

  assign tx_bit         = tx_q;
  assign host.busy      = busy_q;
  assign host.done      = done_q;
  assign host.error_out = err_q;
`ifdef CAN_TX_ARB_EN
  assign host.arb_lost  = arb_q;
`else
  assign host.arb_lost  = 1'b0;
`endif

endmodule

// File: tb/tb_can_frame_tx.sv
// Directed bench for can_frame_tx: a reference model builds each frame's stuffed
// bit stream into a scoreboard queue; each bit_tick pops and compares tx_bit.
module tb_can_frame_tx;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic bit_tick;
  logic rx_bit;
  logic tx_bit;
  logic ack_dom, rx_ovr_en, rx_ovr_val;

  can_frame_tx_if hif ();

  can_frame_tx dut (
    .clock    (clock),
    .reset    (reset),
    .bit_tick (bit_tick),
    .rx_bit   (rx_bit),
    .tx_bit   (tx_bit),
    .host     (hif.slave)
  );

  always #5 clock = ~clock;

  // Wired-AND bus: DUT loopback, bench-driven ACK, or a forced level
  assign rx_bit = rx_ovr_en ? rx_ovr_val : (tx_bit & ~ack_dom);

  logic  exp_q[$];
  int    ack_idx, drv;
  int    n_chk = 0, n_pass = 0;
  string frame_name;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s/%s: observed %b expected %b", frame_name, tag, obs, exp);
  endtask

  // Reference stream: fields, CRC over raw bits, stuffing, then fixed tail
  task automatic build(input logic [28:0] id, input logic ide, input logic rtr,
                       input logic [3:0] dlc, input logic [63:0] data);
    logic raw[$];
    logic [14:0] crc;
    logic last, nx;
    int run, nb;
    exp_q.delete();
    raw.push_back(1'b0);
    if (ide) begin
      for (int i = 28; i >= 18; i--) raw.push_back(id[i]);
      raw.push_back(1'b1);
      raw.push_back(1'b1);
      for (int i = 17; i >= 0; i--) raw.push_back(id[i]);
      raw.push_back(rtr);
      raw.push_back(1'b0);
      raw.push_back(1'b0);
    end else begin
      for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
      raw.push_back(rtr);
      raw.push_back(1'b0);
      raw.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < nb * 8; i++) raw.push_back(data[63 - i]);
    crc = '0;
    foreach (raw[i]) begin
      nx  = raw[i] ^ crc[14];
      crc = {crc[13:0], 1'b0} ^ (nx ? 15'h4599 : 15'h0000);
    end
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    last = 1'b1;
    run  = 0;
    foreach (raw[i]) begin
      exp_q.push_back(raw[i]);
      run  = (raw[i] == last) ? run + 1 : 1;
      last = raw[i];
      if (run == 5) begin
        exp_q.push_back(~last);
        last = ~last;
        run  = 1;
      end
    end
    for (int i = 0; i < 13; i++) exp_q.push_back(1'b1);
    ack_idx = exp_q.size() - 12;
    drv = 0;
  endtask

  task automatic do_tick();
    repeat (2) @(posedge clock);
    @(negedge clock);
    bit_tick = 1'b1;
    @(posedge clock);
    #1;
    bit_tick = 1'b0;
  endtask

  task automatic start_frame(input logic [28:0] id, input logic ide, input logic rtr,
                             input logic [3:0] dlc, input logic [63:0] data);
    build(id, ide, rtr, dlc, data);
    @(negedge clock);
    hif.id_in = id; hif.ide_in = ide; hif.rtr_in = rtr; hif.dlc_in = dlc; hif.data_in = data;
    hif.start = 1'b1;
    @(posedge clock);
    #1;
    hif.start = 1'b0;
    check("accept_busy", hif.busy, 1'b1);
    check("accept_tx_idle", tx_bit, 1'b1);
  endtask

  task automatic play(input int n, input logic ack_ok);
    logic e;
    for (int k = 0; k < n; k++) begin
      do_tick();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      check($sformatf("tx_bit[%0d]", drv), tx_bit, e);
      check("error_out", hif.error_out, (!ack_ok && drv == ack_idx + 1));
      check("busy_in_frame", hif.busy, 1'b1);
      check("done_in_frame", hif.done, 1'b0);
      ack_dom = (drv == ack_idx) ? ack_ok : 1'b0;
      drv++;
    end
  endtask

  task automatic finish_frame();
    do_tick();
    check("done_pulse", hif.done, 1'b1);
    check("busy_clear", hif.busy, 1'b0);
    check("tx_recessive", tx_bit, 1'b1);
    check("no_arb_lost", hif.arb_lost, 1'b0);
    @(posedge clock);
    #1;
    check("done_one_cycle", hif.done, 1'b0);
  endtask

  task automatic full_frame(input string nm, input logic [28:0] id, input logic ide,
                            input logic rtr, input logic [3:0] dlc, input logic [63:0] data,
                            input logic ack_ok);
    frame_name = nm;
    start_frame(id, ide, rtr, dlc, data);
    play(exp_q.size(), ack_ok);
    finish_frame();
  endtask

  initial begin
    bit_tick = 1'b0; ack_dom = 1'b0; rx_ovr_en = 1'b0; rx_ovr_val = 1'b1;
    hif.start = 1'b0; hif.error_in = 1'b0; hif.id_in = '0; hif.ide_in = 1'b0;
    hif.rtr_in = 1'b0; hif.dlc_in = '0; hif.data_in = '0;
    frame_name = "reset";
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_tx", tx_bit, 1'b1);
    check("rst_busy", hif.busy, 1'b0);
    check("rst_done", hif.done, 1'b0);
    check("rst_err", hif.error_out, 1'b0);
    check("rst_arb", hif.arb_lost, 1'b0);
    @(negedge clock) reset = 1'b1;

    // All-zero base frame: heavy stuffing in ID
    full_frame("zero_id", 29'h0, 1'b0, 1'b0, 4'd0, 64'h0, 1'b1);

    // Base frame with one data byte; a start mid-frame must be ignored
    frame_name = "id123";
    start_frame(29'h123, 1'b0, 1'b0, 4'd1, 64'hAA00_0000_0000_0000);
    play(10, 1'b1);
    @(negedge clock);
    hif.start = 1'b1; hif.id_in = 29'h7FF; hif.dlc_in = 4'd8;
    @(posedge clock);
    #1 hif.start = 1'b0;
    play(exp_q.size(), 1'b1);
    finish_frame();

    // Extended frame, DLC above 8 clamps to 64 data bits
    full_frame("ext_dlc12", 29'h1ABCDE12, 1'b1, 1'b0, 4'd12, 64'h0123_4567_89AB_CDEF, 1'b1);

    // Remote frame with no ACK; a start held over the done clock is taken one clock later
    frame_name = "rtr_noack";
    start_frame(29'h7FF, 1'b0, 1'b1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    play(exp_q.size(), 1'b0);
    build(29'h00000FFF, 1'b1, 1'b1, 4'd0, 64'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    hif.id_in = 29'h00000FFF; hif.ide_in = 1'b1; hif.rtr_in = 1'b1; hif.dlc_in = 4'd0;
    hif.data_in = 64'h0; hif.start = 1'b1; bit_tick = 1'b1;
    @(posedge clock);
    #1 bit_tick = 1'b0;
    check("done_pulse", hif.done, 1'b1);
    check("start_ignored_on_done", hif.busy, 1'b0);
    @(posedge clock);
    #1 hif.start = 1'b0;
    check("start_after_done", hif.busy, 1'b1);
    frame_name = "chained_ext_rtr";
    play(exp_q.size(), 1'b1);
    finish_frame();

    // Abort in DATA via error_in
    frame_name = "abort_data";
    start_frame(29'h2A5, 1'b0, 1'b0, 4'd8, 64'hFFFF_0000_FFFF_0000);
    play(30, 1'b1);
    @(negedge clock) hif.error_in = 1'b1;
    @(posedge clock);
    #1 hif.error_in = 1'b0;
    check("abort_tx", tx_bit, 1'b1);
    check("abort_busy", hif.busy, 1'b0);
    do_tick();
    check("abort_idle_tx", tx_bit, 1'b1);
    check("abort_no_done", hif.done, 1'b0);
    @(negedge clock);
    hif.start = 1'b1; hif.error_in = 1'b1;
    @(posedge clock);
    #1;
    hif.start = 1'b0; hif.error_in = 1'b0;
    check("error_beats_start", hif.busy, 1'b0);
    full_frame("after_abort", 29'h0F0, 1'b0, 1'b0, 4'd2, 64'h5A5A_0000_0000_0000, 1'b1);

    // Asynchronous reset inside CRC
    frame_name = "reset_crc";
    start_frame(29'h555, 1'b0, 1'b0, 4'd0, 64'h0);
    play(24, 1'b1);
    #3 reset = 1'b0;
    #1;
    check("rst_mid_tx", tx_bit, 1'b1);
    check("rst_mid_busy", hif.busy, 1'b0);
    @(negedge clock) reset = 1'b1;
    full_frame("after_reset", 29'h001, 1'b0, 1'b0, 4'd0, 64'h0, 1'b1);

    // Dominant forced onto a recessive identifier bit
    frame_name = "arb";
    start_frame(29'h400, 1'b0, 1'b0, 4'd0, 64'h0);
    play(2, 1'b1);
    rx_ovr_en = 1'b1; rx_ovr_val = 1'b0;
    do_tick();
`ifdef CAN_TX_ARB_EN
    check("arb_lost_pulse", hif.arb_lost, 1'b1);
    check("arb_tx", tx_bit, 1'b1);
    check("arb_busy", hif.busy, 1'b0);
    rx_ovr_en = 1'b0;
    @(posedge clock);
    #1 check("arb_one_cycle", hif.arb_lost, 1'b0);
`else
    check("arb_disabled", hif.arb_lost, 1'b0);
    check("arb_disabled_busy", hif.busy, 1'b1);
    rx_ovr_en = 1'b0;
    @(negedge clock) hif.error_in = 1'b1;
    @(posedge clock);
    #1 hif.error_in = 1'b0;
    check("arb_abort_busy", hif.busy, 1'b0);
`endif
    exp_q.delete();
    full_frame("after_arb", 29'h3C3, 1'b0, 1'b0, 4'd3, 64'hC3A5_0F00_0000_0000, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
